// File: rtl/aig_latch_checker.sv
// aig_latch_checker: self-checking responder for the AIGER latch regression flow.
// Holds a one-event-delayed reference copy of the stimulus. On each enable event it
// compares the DUT output against that copy. It counts mismatches, records the index
// of the first mismatch, and reports pass/fail after a bounded number of compared events.
module aig_latch_checker #(
  parameter int unsigned WIDTH      = 1,
  parameter int unsigned NUM_CHECKS = 10000,
  parameter int unsigned SETTLE     = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] dut_q,
  input  logic             start,
  input  logic             clear,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [CNT_W-1:0] event_count
);

  localparam logic [CNT_W-1:0] NumChecksC = CNT_W'(NUM_CHECKS);
  localparam logic [CNT_W-1:0] SettleC    = CNT_W'(SETTLE);
  localparam logic [CNT_W-1:0] OneC       = CNT_W'(1);
  localparam logic [CNT_W-1:0] ErrMaxC    = {CNT_W{1'b1}};
  localparam bit               HasSettle  = (SETTLE != 0);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSettle = 2'd1,
    StCheck  = 2'd2,
    StDone   = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   ref_q, ref_d;
  logic [CNT_W-1:0]   settle_q, settle_d;
  logic [CNT_W-1:0]   evt_q, evt_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic [CNT_W-1:0]   first_q, first_d;
  logic               fail_q, fail_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic               mismatch;

  // State and datapath registers; reset discards any run in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      ref_q    <= '0;
      settle_q <= '0;
      evt_q    <= '0;
      err_q    <= '0;
      first_q  <= '0;
      fail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ref_q    <= ref_d;
      settle_q <= settle_d;
      evt_q    <= evt_d;
      err_q    <= err_d;
      first_q  <= first_d;
      fail_q   <= fail_d;
    end
  end

  // Next-state logic: reference update, compare and bookkeeping per enable event.
  always_comb begin
    state_d  = state_q;
    ref_d    = ref_q;
    settle_d = settle_q;
    evt_d    = evt_q;
    err_d    = err_q;
    first_d  = first_q;
    fail_d   = fail_q;
    // Case inequality so that X/Z from the DUT is flagged in simulation.
    mismatch = (dut_q !== ref_q);

    if (clear) begin
      // Clear wins over start and over any event in the same cycle.
      state_d  = StIdle;
      ref_d    = '0;
      settle_d = '0;
      evt_d    = '0;
      err_d    = '0;
      first_d  = '0;
      fail_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // The start edge primes the reference but is not itself an event.
          if (start) begin
            ref_d   = din;
            evt_d   = '0;
            err_d   = '0;
            first_d = '0;
            fail_d  = 1'b0;
            if (HasSettle) begin
              settle_d = SettleC;
              state_d  = StSettle;
            end else begin
              settle_d = '0;
              state_d  = StCheck;
            end
          end
        end
        StSettle: begin
          if (en) begin
            ref_d    = din;
            settle_d = settle_q - OneC;
            if (settle_q == OneC) begin
              state_d = StCheck;
            end
          end
        end
        StCheck: begin
          if (en) begin
            ref_d = din;
            evt_d = evt_q + OneC;
            if (mismatch) begin
              if (err_q != ErrMaxC) begin
                err_d = err_q + OneC;
              end
              if (!fail_q) begin
                fail_d  = 1'b1;
                first_d = evt_q;
              end
            end
            if (evt_d == NumChecksC) begin
              state_d = StDone;
            end
          end
        end
        StDone: begin
          // Result holds until clear or reset; start is ignored here.
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // Status flags derived from the next state so they land in the same edge as the state.
  always_comb begin
    busy_d = (state_d == StSettle) || (state_d == StCheck);
    done_d = (state_d == StDone);
    pass_d = (state_d == StDone) && (err_d == '0);
  end

  // Registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      pass_q <= pass_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign fail          = fail_q;
  assign err_count     = err_q;
  assign first_err_idx = first_q;
  assign event_count   = evt_q;

  // Structural invariants of the run bookkeeping.
  a_evt_bound : assert property (@(posedge clk) disable iff (!rst_n) evt_q <= NumChecksC);
  a_pass_done : assert property (@(posedge clk) disable iff (!rst_n) pass_q |-> done_q);
  a_busy_done : assert property (@(posedge clk) disable iff (!rst_n) !(busy_q && done_q));

endmodule

// File: tb/tb_aig_latch_checker.sv
// Bench for aig_latch_checker: scoreboarded expectations pushed at stimulus time and
// popped after the clock edge that should produce them.
module tb_aig_latch_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Unit 1: WIDTH=1, NUM_CHECKS=8, SETTLE=1, CNT_W=16.
  logic        en1, din1, dutq1, start1, clear1;
  logic        busy1, done1, pass1, fail1;
  logic [15:0] err1, first1, evt1;

  // Unit 2: WIDTH=4, NUM_CHECKS=15, SETTLE=0, CNT_W=4.
  logic       en2, start2, clear2;
  logic [3:0] din2, dutq2;
  logic       busy2, done2, pass2, fail2;
  logic [3:0] err2, first2, evt2;

  aig_latch_checker #(.WIDTH(1), .NUM_CHECKS(8), .SETTLE(1), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .din(din1), .dut_q(dutq1), .start(start1),
    .clear(clear1), .busy(busy1), .done(done1), .pass(pass1), .fail(fail1),
    .err_count(err1), .first_err_idx(first1), .event_count(evt1)
  );

  aig_latch_checker #(.WIDTH(4), .NUM_CHECKS(15), .SETTLE(0), .CNT_W(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .en(en2), .din(din2), .dut_q(dutq2), .start(start2),
    .clear(clear2), .busy(busy2), .done(done2), .pass(pass2), .fail(fail2),
    .err_count(err2), .first_err_idx(first2), .event_count(evt2)
  );

  typedef struct {
    string       tag;
    int          unit;
    logic        busy, done, pass, fail;
    logic [15:0] err, first, evt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic last1;
  logic [3:0] last2;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
  endtask

  task automatic push_exp(input string tag, input int unit, input logic b, input logic d,
                          input logic p, input logic f, input int err, input int first,
                          input int evt);
    exp_t e;
    e.tag = tag; e.unit = unit;
    e.busy = b; e.done = d; e.pass = p; e.fail = f;
    e.err = 16'(err); e.first = 16'(first); e.evt = 16'(evt);
    sb.push_back(e);
  endtask

  // Pops the oldest expectation and compares it against the addressed unit's outputs.
  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      $display("FAIL scoreboard_empty: got 0 entries, want >=1");
      return;
    end
    e = sb.pop_front();
    if (e.unit == 1) begin
      check_val({e.tag, ".busy"},  {31'd0, busy1}, {31'd0, e.busy});
      check_val({e.tag, ".done"},  {31'd0, done1}, {31'd0, e.done});
      check_val({e.tag, ".pass"},  {31'd0, pass1}, {31'd0, e.pass});
      check_val({e.tag, ".fail"},  {31'd0, fail1}, {31'd0, e.fail});
      check_val({e.tag, ".err"},   {16'd0, err1},   {16'd0, e.err});
      check_val({e.tag, ".first"}, {16'd0, first1}, {16'd0, e.first});
      check_val({e.tag, ".evt"},   {16'd0, evt1},   {16'd0, e.evt});
    end else begin
      check_val({e.tag, ".busy"},  {31'd0, busy2}, {31'd0, e.busy});
      check_val({e.tag, ".done"},  {31'd0, done2}, {31'd0, e.done});
      check_val({e.tag, ".pass"},  {31'd0, pass2}, {31'd0, e.pass});
      check_val({e.tag, ".fail"},  {31'd0, fail2}, {31'd0, e.fail});
      check_val({e.tag, ".err"},   {28'd0, err2},   {16'd0, e.err});
      check_val({e.tag, ".first"}, {28'd0, first2}, {16'd0, e.first});
      check_val({e.tag, ".evt"},   {28'd0, evt2},   {16'd0, e.evt});
    end
  endtask

  // One clock on unit 1; inputs driven away from the edge, sampled on the falling edge.
  task automatic tick1(input logic e, input logic d, input logic q, input logic s,
                       input logic c);
    en1 = e; din1 = d; dutq1 = q; start1 = s; clear1 = c;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0; clear1 = 1'b0;
  endtask

  task automatic tick2(input logic e, input logic [3:0] d, input logic [3:0] q,
                       input logic s);
    en2 = e; din2 = d; dutq2 = q; start2 = s; clear2 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start2 = 1'b0;
  endtask

  // Enable event on unit 1 with din toggling; dut_q is the ideal DFF output unless bad.
  task automatic ev1(input logic bad);
    logic nd;
    nd = ~last1;
    tick1(1'b1, nd, bad ? ~last1 : last1, 1'b0, 1'b0);
    last1 = nd;
  endtask

  // Non-event cycle with garbage on din/dut_q.
  task automatic idle1();
    tick1(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
  endtask

  task automatic start1_run();
    last1 = 1'($urandom_range(0, 1));
    tick1(1'b1, last1, ~last1, 1'b1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    en1 = 0; din1 = 0; dutq1 = 0; start1 = 0; clear1 = 0;
    en2 = 0; din2 = 0; dutq2 = 0; start2 = 0; clear2 = 0;
    last1 = 0; last2 = 0;
    repeat (2) @(negedge clk);
    push_exp("reset", 1, 0, 0, 0, 0, 0, 0, 0);
    pop_check();
    push_exp("reset2", 2, 0, 0, 0, 0, 0, 0, 0);
    pop_check();
    rst_n = 1'b1;
    @(negedge clk);

    // Match run with en toggling, plus a 5-cycle en-low gap with garbage.
    push_exp("m_start", 1, 1, 0, 0, 0, 0, 0, 0);
    start1_run();
    pop_check();
    push_exp("m_settle", 1, 1, 0, 0, 0, 0, 0, 0);
    ev1(1'b0);
    pop_check();
    for (int k = 0; k < 8; k++) begin
      push_exp("m_evt", 1, k < 7, k == 7, k == 7, 0, 0, 0, k + 1);
      ev1(1'b0);
      pop_check();
      idle1();
      if (k == 3) begin
        repeat (5) idle1();
        push_exp("m_gap", 1, 1, 0, 0, 0, 0, 0, 4);
        pop_check();
      end
    end
    push_exp("m_start_in_done", 1, 0, 1, 1, 0, 0, 0, 8);
    tick1(1'b1, ~last1, ~last1, 1'b1, 1'b0);
    pop_check();
    push_exp("m_hold", 1, 0, 1, 1, 0, 0, 0, 8);
    ev1(1'b1);
    pop_check();

    // Single fault at compared event index 3.
    push_exp("f_clear", 1, 0, 0, 0, 0, 0, 0, 0);
    tick1(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    pop_check();
    start1_run();
    ev1(1'b0);
    for (int k = 0; k < 8; k++) begin
      push_exp("f_evt", 1, k < 7, k == 7, 0, k >= 3, (k >= 3) ? 1 : 0, (k >= 3) ? 3 : 0, k + 1);
      ev1(k == 3);
      pop_check();
    end

    // Clear during CHECK at event 4, then start+clear together.
    tick1(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    start1_run();
    ev1(1'b0);
    for (int k = 0; k < 4; k++) ev1(k == 2);
    push_exp("c_pre", 1, 1, 0, 0, 1, 1, 2, 4);
    pop_check();
    push_exp("c_clear", 1, 0, 0, 0, 0, 0, 0, 0);
    tick1(1'b1, ~last1, ~last1, 1'b0, 1'b1);
    pop_check();
    push_exp("c_start_clear", 1, 0, 0, 0, 0, 0, 0, 0);
    tick1(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    pop_check();
    push_exp("c_still_idle", 1, 0, 0, 0, 0, 0, 0, 0);
    ev1(1'b1);
    pop_check();

    // Asynchronous reset between edges during CHECK.
    start1_run();
    ev1(1'b0);
    for (int k = 0; k < 3; k++) ev1(k == 1);
    #2 rst_n = 1'b0;
    #1;
    push_exp("r_async", 1, 0, 0, 0, 0, 0, 0, 0);
    pop_check();
    @(negedge clk);
    rst_n = 1'b1;
    push_exp("r_start", 1, 1, 0, 0, 0, 0, 0, 0);
    start1_run();
    pop_check();
    ev1(1'b0);
    for (int k = 0; k < 8; k++) ev1(1'b0);
    push_exp("r_final", 1, 0, 1, 1, 0, 0, 0, 8);
    pop_check();

    // Saturation on unit 2 (no settle phase): every compare wrong.
    last2 = 4'($urandom_range(0, 15));
    push_exp("s_start", 2, 1, 0, 0, 0, 0, 0, 0);
    tick2(1'b1, last2, ~last2, 1'b1);
    pop_check();
    for (int k = 0; k < 18; k++) begin
      logic [3:0] nd;
      nd = 4'($urandom_range(0, 15));
      push_exp("s_evt", 2, k < 14, k >= 14, 0, 1, (k < 15) ? k + 1 : 15, 0, (k < 15) ? k + 1 : 15);
      tick2(1'b1, nd, ~last2, 1'b0);
      last2 = nd;
      pop_check();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/aig_latch_checker.md
Name: aig_latch_checker

Overview:
- Synthesizable self-checking responder for the AIGER latch regression flow.
- Sits on the far side of the DUT from the stimulus generator. It keeps a DFF-semantics reference copy of the stimulus data and compares the DUT output against it on every enable event.
- It accumulates a mismatch count, captures the first failing event, and reports pass/fail at the end of a bounded run.
- Replaces the ad-hoc per-test comparator, so a single netlist can run under simulation and formal.

Parameters:
WIDTH, 1, data width of din/dut_q
NUM_CHECKS, 10000, number of compared enable events per run (>=1)
SETTLE, 1, enable events after start that update the reference without comparing (>=0)
CNT_W, 16, width of err_count and event/index counters

Ports:
clk  input  1  clock; all state on rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  enable event qualifier; event = rising clk edge with en=1
din  input  WIDTH  stimulus data fed to the DUT and reference
dut_q  input  WIDTH  DUT output under test
start  input  1  one-cycle pulse; begins a run from IDLE
clear  input  1  one-cycle pulse; aborts and zeroes everything
busy  output  1  high in SETTLE or CHECK
done  output  1  high in DONE
pass  output  1  high in DONE when err_count==0
fail  output  1  sticky; high from first mismatch until clear/reset
err_count  output  CNT_W  mismatch count, saturates at all-ones
first_err_idx  output  CNT_W  check-event index (0-based) of first mismatch; 0 if none
event_count  output  CNT_W  compared events so far in this run

Behaviour:
- Reset (rst_n=0, asynchronous) forces the following:
  - state=IDLE; ref_q=0; all counters 0.
  - busy=done=pass=fail=0.
  - Reset mid-run discards the run; no partial result is kept.
- Reference model: on each event in SETTLE or CHECK, ref_q <= din. The comparison at an event uses the ref_q held before that edge, i.e. dut_q must equal din from the previous event (one-event DFF latency).
- States:
  - IDLE: start=1 -> ref_q<=din.
    - If SETTLE=0, go to CHECK.
    - Otherwise load the settle counter and go to SETTLE.
    - The start edge itself is not an event.
  - SETTLE: each event decrements the settle counter and updates ref_q, with no compare. On the event where the counter reaches 0, go to CHECK.
  - CHECK: each event compares dut_q vs ref_q, increments event_count, and updates ref_q.
    - On mismatch, err_count++ (saturating).
    - On the first mismatch, also set fail=1 and first_err_idx=event_count (pre-increment).
    - When event_count reaches NUM_CHECKS (counting the current event), go to DONE.
  - DONE: outputs hold; done=1; pass=(err_count==0). start is ignored.
- Non-event cycles (en=0) change no state other than accepting start/clear.
- start is ignored outside IDLE.
- clear in any state is synchronous: go to IDLE, zero counters, and drop fail/pass/done.
- clear and start in the same cycle: clear wins; the run does not begin.
- Compare is full-width bitwise. In simulation, X/Z on dut_q counts as a mismatch (case inequality).
- Counter width: NUM_CHECKS must fit in CNT_W. event_count never exceeds NUM_CHECKS.
- Outputs are registered. A mismatch at edge N is visible on fail/err_count after edge N.

Test Plan:
- Match run: WIDTH=1, NUM_CHECKS=8, SETTLE=1, en toggling every cycle, din toggling each event, dut_q = din delayed one event -> done after 9 events post-start, pass=1, fail=0, err_count=0, event_count=8.
- Single fault: same setup, dut_q forced inverted at compared event 3 only -> fail=1 after that edge, err_count=1, first_err_idx=3, done with pass=0.
- Saturation: CNT_W=4, NUM_CHECKS=15, dut_q always wrong -> err_count=15 (all-ones) and holds, first_err_idx=0, pass=0.
- en gating: en held low 5 cycles mid-run with dut_q garbage -> event_count, err_count and ref_q unchanged across the gap; final result pass=1.
- Control races: start+clear in same cycle -> stays IDLE, busy=0. clear during CHECK at event 4 -> IDLE, all counters 0, fail=0. start while in DONE -> ignored.
- Async reset: rst_n pulsed low between clock edges during CHECK -> outputs zero immediately, not at the next edge. After release, a new start runs cleanly to pass=1.
